// File: rtl/his_peak_finder_pkg.sv
// Shared defaults and FSM state encoding for the histogram peak finder.
package his_peak_finder_pkg;

    localparam int NB_DEF      = 6;
    localparam int CNT_W_DEF   = 12;
    localparam int PIX_NUM_DEF = 200;
    localparam int PIX_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/his_peak_finder_compare.sv
// peakCompare: running maximum over a stream of (bin, count) pairs.
// The update is strictly-greater, so equal counts keep the lowest bin.
module peakCompare #(
    parameter int NB    = 6,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             res,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [NB-1:0]    i_bin,
    input  logic [CNT_W-1:0] i_data,
    output logic [NB-1:0]    o_max_bin,
    output logic [CNT_W-1:0] o_max_cnt
);

    logic [NB-1:0]    r_max_bin;
    logic [CNT_W-1:0] r_max_cnt;

    // Running max register; clear has priority over a new sample
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_max_bin <= {NB{1'b0}};
            r_max_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_max_bin <= {NB{1'b0}};
            r_max_cnt <= {CNT_W{1'b0}};
        end else if (i_valid && (i_data > r_max_cnt)) begin
            r_max_bin <= i_bin;
            r_max_cnt <= i_data;
        end else begin
            r_max_bin <= r_max_bin;
            r_max_cnt <= r_max_cnt;
        end
    end

    assign o_max_bin = r_max_bin;
    assign o_max_cnt = r_max_cnt;

endmodule

// File: rtl/his_peak_finder.sv
// his_peak_finder: scans each pixel histogram of a completed bank and reports its peak bin.
// Optional macro PEAK_THRESH_EN adds input thr and output peakHit (peakCount >= thr).
module his_peak_finder
    import his_peak_finder_pkg::*;
#(
    parameter int NB      = NB_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PIX_NUM = PIX_NUM_DEF
) (
    input  logic             clk,
    input  logic             res,
`ifdef PEAK_THRESH_EN
    input  logic [CNT_W-1:0] thr,
    output logic             peakHit,
`endif
    input  logic             hisNum,
    output logic             rdEn,
    output logic             rdBank,
    output logic [PIX_W-1:0] rdPix,
    output logic [NB-1:0]    rdBin,
    input  logic [CNT_W-1:0] rdData,
    output logic             peakValid,
    input  logic             peakReady,
    output logic [PIX_W-1:0] peakPix,
    output logic [NB-1:0]    peakBin,
    output logic [CNT_W-1:0] peakCount,
    output logic             frameDone,
    output logic             overrun,
    output logic             busy
);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_NUM - 1);
    localparam logic [NB-1:0]    LAST_BIN = {NB{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic             r_hisNum_d;
    logic             r_bank;
    logic [PIX_W-1:0] r_pix;
    logic [NB-1:0]    r_bin;
    logic             r_rdEn;
    logic             r_busy;
    logic             r_rd_vld;
    logic [NB-1:0]    r_rd_bin;
    logic             r_overrun;
    logic             r_peakValid;
    logic [PIX_W-1:0] r_peakPix;
    logic [NB-1:0]    r_peakBin;
    logic [CNT_W-1:0] r_peakCount;
    logic             r_frameDone;
    logic             w_start;
    logic             w_hs;
    logic             w_last_pix;
    logic             w_clr;
    logic             w_load;
    logic [NB-1:0]    w_max_bin;
    logic [CNT_W-1:0] w_max_cnt;

    assign w_start    = hisNum ^ r_hisNum_d;
    assign w_hs       = (r_state == ST_REPORT) && r_peakValid && peakReady;
    assign w_last_pix = (r_pix == LAST_PIX);
    assign w_clr      = ((r_state == ST_IDLE) && w_start) || w_hs;
    assign w_load     = (r_state == ST_REPORT) && !r_peakValid;

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_SCAN;
                else         w_next = ST_IDLE;
            end
            ST_SCAN: begin
                if (r_bin == LAST_BIN) w_next = ST_DRAIN;
                else                   w_next = ST_SCAN;
            end
            ST_DRAIN: w_next = ST_REPORT;
            ST_REPORT: begin
                if (w_hs) w_next = w_last_pix ? ST_IDLE : ST_SCAN;
                else      w_next = ST_REPORT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Read-address generation and return-data alignment
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_hisNum_d <= 1'b0;
            r_bank     <= 1'b0;
            r_pix      <= {PIX_W{1'b0}};
            r_bin      <= {NB{1'b0}};
            r_rdEn     <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_bin   <= {NB{1'b0}};
        end else begin
            r_hisNum_d <= hisNum;
            r_rdEn     <= (w_next == ST_SCAN);
            r_busy     <= (w_next != ST_IDLE);
            r_rd_vld   <= r_rdEn;
            r_rd_bin   <= r_bin;
            if (r_state == ST_SCAN) r_bin <= r_bin + NB'(1);
            else                    r_bin <= {NB{1'b0}};
            // The bank that just completed is the one hisNum pointed at before the toggle
            if ((r_state == ST_IDLE) && w_start) begin
                r_bank <= r_hisNum_d;
                r_pix  <= {PIX_W{1'b0}};
            end else if (w_hs && !w_last_pix) begin
                r_bank <= r_bank;
                r_pix  <= r_pix + 8'd1;
            end else begin
                r_bank <= r_bank;
                r_pix  <= r_pix;
            end
        end
    end

    // Sticky overrun: a bank completed while a frame was still in progress
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_overrun <= 1'b0;
        end else if (w_start && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    peakCompare #(
        .NB    (NB),
        .CNT_W (CNT_W)
    ) u_cmp (
        .clk       (clk),
        .res       (res),
        .i_clr     (w_clr),
        .i_valid   (r_rd_vld),
        .i_bin     (r_rd_bin),
        .i_data    (rdData),
        .o_max_bin (w_max_bin),
        .o_max_cnt (w_max_cnt)
    );

    // Result registers: captured on the first REPORT cycle, held until accepted
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_peakValid <= 1'b0;
            r_peakPix   <= {PIX_W{1'b0}};
            r_peakBin   <= {NB{1'b0}};
            r_peakCount <= {CNT_W{1'b0}};
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_hs && w_last_pix;
            if (w_load) begin
                r_peakValid <= 1'b1;
                r_peakPix   <= r_pix;
                r_peakBin   <= w_max_bin;
                r_peakCount <= w_max_cnt;
            end else if (w_hs) begin
                r_peakValid <= 1'b0;
            end else begin
                r_peakValid <= r_peakValid;
            end
        end
    end

`ifdef PEAK_THRESH_EN
    logic r_peakHit;

    // Threshold flag follows thr while a result is being reported
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_peakHit <= 1'b0;
        end else if (r_state == ST_REPORT) begin
            r_peakHit <= (w_max_cnt >= thr);
        end else begin
            r_peakHit <= r_peakHit;
        end
    end

    assign peakHit = r_peakHit;
`endif

    assign rdEn      = r_rdEn;
    assign rdBank    = r_bank;
    assign rdPix     = r_pix;
    assign rdBin     = r_bin;
    assign peakValid = r_peakValid;
    assign peakPix   = r_peakPix;
    assign peakBin   = r_peakBin;
    assign peakCount = r_peakCount;
    assign frameDone = r_frameDone;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_his_peak_finder.sv
// Directed bench for his_peak_finder (NB=3, PIX_NUM=2, CNT_W=8) with a one-cycle-latency RAM model.
module tb_his_peak_finder;

    localparam int NB    = 3;
    localparam int CNT_W = 8;
    localparam int PIXN  = 2;

    logic             clk = 1'b0;
    logic             res;
    logic             hisNum;
    logic             rdEn;
    logic             rdBank;
    logic [7:0]       rdPix;
    logic [NB-1:0]    rdBin;
    logic [CNT_W-1:0] rdData = 8'd0;
    logic             peakValid;
    logic             peakReady;
    logic [7:0]       peakPix;
    logic [NB-1:0]    peakBin;
    logic [CNT_W-1:0] peakCount;
    logic             frameDone;
    logic             overrun;
    logic             busy;
`ifdef PEAK_THRESH_EN
    logic [CNT_W-1:0] thr;
    logic             peakHit;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [2][2][8];

    his_peak_finder #(.NB(NB), .CNT_W(CNT_W), .PIX_NUM(PIXN)) dut (
        .clk       (clk),
        .res       (res),
`ifdef PEAK_THRESH_EN
        .thr       (thr),
        .peakHit   (peakHit),
`endif
        .hisNum    (hisNum),
        .rdEn      (rdEn),
        .rdBank    (rdBank),
        .rdPix     (rdPix),
        .rdBin     (rdBin),
        .rdData    (rdData),
        .peakValid (peakValid),
        .peakReady (peakReady),
        .peakPix   (peakPix),
        .peakBin   (peakBin),
        .peakCount (peakCount),
        .frameDone (frameDone),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Histogram RAM: data returned one cycle after the read strobe
    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdBank][rdPix[0]][rdBin];
        else      rdData <= 8'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_pix(input int b, input int p, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mem[b][p][i] = v[i*8 +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that entered SCAN; ends on the cycle peakValid rises
    task automatic run_pixel(input int bank, input int pix, input int exp_bin,
                             input int exp_cnt, input int tog_at);
        for (int i = 0; i < 8; i++) begin
            check("scan_rdEn", 32'(rdEn), 32'd1);
            check("scan_rdBin", 32'(rdBin), 32'(i));
            check("scan_rdPix", 32'(rdPix), 32'(pix));
            check("scan_rdBank", 32'(rdBank), 32'(bank));
            check("scan_busy", 32'(busy), 32'd1);
            if (i == tog_at) hisNum = ~hisNum;
            tick();
        end
        check("drain_rdEn", 32'(rdEn), 32'd0);
        check("drain_valid", 32'(peakValid), 32'd0);
        tick();
        check("rep0_rdEn", 32'(rdEn), 32'd0);
        check("rep0_valid", 32'(peakValid), 32'd0);
        tick();
        check("latency_valid", 32'(peakValid), 32'd1);
        check("peakPix", 32'(peakPix), 32'(pix));
        check("peakBin", 32'(peakBin), 32'(exp_bin));
        check("peakCount", 32'(peakCount), 32'(exp_cnt));
    endtask

    task automatic handshake();
        peakReady = 1'b1;
        tick();
        peakReady = 1'b0;
        check("hs_valid_drop", 32'(peakValid), 32'd0);
    endtask

    initial begin
        res       = 1'b0;
        hisNum    = 1'b0;
        peakReady = 1'b0;
`ifdef PEAK_THRESH_EN
        thr       = 8'd0;
`endif
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < 2; p++) load_pix(b, p, 64'd0);
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdEn", 32'(rdEn), 32'd0);
        check("rst_valid", 32'(peakValid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frameDone", 32'(frameDone), 32'd0);
        check("rst_peakCount", 32'(peakCount), 32'd0);
`ifdef PEAK_THRESH_EN
        check("rst_peakHit", 32'(peakHit), 32'd0);
`endif
        res = 1'b1;
        tick();

        // Reset in the middle of a scan
        hisNum = 1'b1;
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_rdEn", 32'(rdEn), 32'd1);
        tick();
        tick();
        res    = 1'b0;
        hisNum = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdEn", 32'(rdEn), 32'd0);
        check("midrst_valid", 32'(peakValid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        res = 1'b1;
        tick();
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Frame 1: bank 0, peak at bin 2 then tie between bins 3 and 6, overrun mid pixel 1
        load_pix(0, 0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd5, 8'd1, 8'd0});
        load_pix(0, 1, {8'd1, 8'd7, 8'd1, 8'd1, 8'd7, 8'd1, 8'd1, 8'd1});
        hisNum = 1'b1;
        tick();
        check("f1_overrun_clear", 32'(overrun), 32'd0);
        run_pixel(0, 0, 2, 5, -1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_valid", 32'(peakValid), 32'd1);
            check("hold_bin", 32'(peakBin), 32'd2);
            check("hold_cnt", 32'(peakCount), 32'd5);
            check("hold_rdEn", 32'(rdEn), 32'd0);
        end
`ifdef PEAK_THRESH_EN
        thr = 8'd6;
        tick();
        tick();
        check("thr6_hit", 32'(peakHit), 32'd0);
        thr = 8'd5;
        tick();
        tick();
        check("thr5_hit", 32'(peakHit), 32'd1);
`endif
        handshake();
        run_pixel(0, 1, 3, 7, 4);
        check("overrun_set", 32'(overrun), 32'd1);
        handshake();
        check("f1_frameDone", 32'(frameDone), 32'd1);
        check("f1_idle", 32'(busy), 32'd0);
        tick();
        check("f1_frameDone_pulse", 32'(frameDone), 32'd0);
        tick();
        check("f1_no_restart", 32'(busy), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Frame 2: bank 0, all-zero pixel then peak on the last bin
        load_pix(0, 0, 64'd0);
        load_pix(0, 1, {8'd9, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3});
        hisNum = 1'b1;
        tick();
        run_pixel(0, 0, 0, 0, -1);
        handshake();
        run_pixel(0, 1, 7, 9, -1);
        handshake();
        check("f2_frameDone", 32'(frameDone), 32'd1);

        // Frame 3: bank 1, peak on first bin then full-scale count on last bin
        load_pix(1, 0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8});
        load_pix(1, 1, {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        tick();
        hisNum = 1'b0;
        tick();
        run_pixel(1, 0, 0, 8, -1);
        handshake();
        run_pixel(1, 1, 7, 255, -1);
        handshake();
        check("f3_frameDone", 32'(frameDone), 32'd1);
        check("f3_idle", 32'(busy), 32'd0);
        check("f3_overrun_sticky", 32'(overrun), 32'd1);
        tick();
        check("f3_frameDone_pulse", 32'(frameDone), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
